// File: rtl/dot_pattern_sched_if.sv
// Request/status bundle between game logic and the dot-matrix pattern scheduler.
interface dot_pattern_sched_if;
    logic       req_correct;
    logic       req_wrong;
    logic       req_fail;
    logic       req_clear;
    logic [1:0] pattern_sel;
    logic [2:0] grant;
    logic       busy;
    logic       locked;
    logic [3:0] wrong_cnt;

    modport master (
        output req_correct, req_wrong, req_fail, req_clear,
        input  pattern_sel, grant, busy, locked, wrong_cnt
    );

    modport slave (
        input  req_correct, req_wrong, req_fail, req_clear,
        output pattern_sel, grant, busy, locked, wrong_cnt
    );
endinterface

// File: rtl/dot_pattern_sched.sv
// Arbitrates correct/wrong/fail display requests, holds each pattern, inserts a blank gap,
// and locks on FAIL after too many wrong answers.
module dot_pattern_sched #(
    parameter int unsigned HOLD_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned MAX_WRONG   = 3
) (
    input  logic              clk,
    input  logic              reset,
    dot_pattern_sched_if.slave bus
);
    localparam int unsigned TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned CW   = 4;

    localparam logic [1:0] PAT_IDLE    = 2'd0;
    localparam logic [1:0] PAT_CORRECT = 2'd1;
    localparam logic [1:0] PAT_WRONG   = 2'd2;
    localparam logic [1:0] PAT_FAIL    = 2'd3;

    typedef enum logic [1:0] {IDLE, SHOW, GAP, LOCK} state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [2:0]    flags, flags_d;          // pending {fail,wrong,correct}
    logic [2:0]    set_req, win;
    logic [2:0]    grant, grant_d;
    logic [1:0]    code, code_d;
    logic [1:0]    pattern_sel, pattern_d;
    logic [CW-1:0] wrong_cnt, wrong_cnt_d;
    logic          busy, locked;

    // Grant is looked ahead one edge so it is registered yet appears in the first IDLE cycle.
    always_comb begin
        state_d     = state;
        timer_d     = timer;
        flags_d     = flags;
        grant_d     = 3'b000;
        code_d      = code;
        wrong_cnt_d = wrong_cnt;
        set_req     = 3'b000;
        win         = 3'b000;
        pattern_d   = PAT_IDLE;

        if (bus.req_clear) begin
            state_d     = IDLE;
            timer_d     = '0;
            flags_d     = 3'b000;
            code_d      = PAT_IDLE;
            wrong_cnt_d = '0;
        end else begin
            if (state != LOCK) begin
                set_req = {bus.req_fail, bus.req_wrong, bus.req_correct};
            end

            unique case (state)
                IDLE: begin
                    if (grant != 3'b000) begin
                        state_d = SHOW;
                        timer_d = TW'(HOLD_CYCLES - 1);
                        code_d  = grant[2] ? PAT_FAIL : (grant[1] ? PAT_WRONG : PAT_CORRECT);
                        if (grant[1] && (wrong_cnt < CW'(MAX_WRONG))) begin
                            wrong_cnt_d = wrong_cnt + CW'(1);
                        end
                    end
                end
                SHOW: begin
                    if (timer == '0) begin
                        if ((code == PAT_FAIL) ||
                            ((code == PAT_WRONG) && (wrong_cnt == CW'(MAX_WRONG)))) begin
                            state_d = LOCK;
                        end else if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            timer_d = TW'(GAP_CYCLES - 1);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        timer_d = timer - TW'(1);
                    end
                end
                GAP: begin
                    if (timer == '0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = timer - TW'(1);
                    end
                end
                LOCK: begin
                    state_d = LOCK;
                end
            endcase

            flags_d = flags | set_req;

            // Fixed priority fail > wrong > correct; one grant per IDLE visit.
            if (state_d == IDLE) begin
                if (flags_d[2]) begin
                    win = 3'b100;
                end else if (flags_d[1]) begin
                    win = 3'b010;
                end else if (flags_d[0]) begin
                    win = 3'b001;
                end
                grant_d = win;
                flags_d = flags_d & ~win;
            end
        end

        unique case (state_d)
            SHOW:    pattern_d = code_d;
            LOCK:    pattern_d = PAT_FAIL;
            default: pattern_d = PAT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            flags       <= 3'b000;
            grant       <= 3'b000;
            code        <= PAT_IDLE;
            wrong_cnt   <= '0;
            pattern_sel <= PAT_IDLE;
            busy        <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            flags       <= flags_d;
            grant       <= grant_d;
            code        <= code_d;
            wrong_cnt   <= wrong_cnt_d;
            pattern_sel <= pattern_d;
            busy        <= (state_d != IDLE);
            locked      <= (state_d == LOCK);
        end
    end

    assign bus.pattern_sel = pattern_sel;
    assign bus.grant       = grant;
    assign bus.busy        = busy;
    assign bus.locked      = locked;
    assign bus.wrong_cnt   = wrong_cnt;
endmodule
